// File: rtl/demux1_4_stream_if.sv
// Stream bundle for the 1-to-4 demultiplexer: one upstream valid/ready port
// with a channel select, and four downstream valid/ready channels packed
// side by side (channel i at out_data[i*WIDTH +: WIDTH]).
interface demux1_4_stream_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [1:0]           sel;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready;
  logic [4*WIDTH-1:0]   out_data;

  // Producer/consumer side (testbench or surrounding logic)
  modport master (
    output in_valid, in_data, sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Demultiplexer side
  modport slave (
    input  in_valid, in_data, sel, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux1_4_stream.sv
// 1-to-4 stream demultiplexer with one holding register per channel.
// A word is routed to channel sel when that channel is empty or is being
// drained in the same cycle; the other channels drain independently.
// Optional feature: define DEMUX_COUNT_EN to add the cnt output, four 8-bit
// wrapping counters of output transfers (channel i at cnt[i*8 +: 8]).
module demux1_4_stream #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  demux1_4_stream_if.slave    bus
`ifdef DEMUX_COUNT_EN
  ,
  output logic [31:0]         cnt
`endif
);

  logic [3:0]             vld_q, vld_d;
  logic [3:0][WIDTH-1:0]  data_q, data_d;
  logic [3:0]             pop;
  logic                   load;

  // A full channel can still accept when its consumer takes the old word now
  assign bus.in_ready = (~vld_q[bus.sel] | bus.out_ready[bus.sel]) & ~reset;
  assign load         = bus.in_valid & bus.in_ready;
  assign pop          = vld_q & bus.out_ready;

  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;

  // Next state: pops clear flags, a load to sel overrides its pop (no loss)
  always_comb begin
    vld_d  = vld_q & ~pop;
    data_d = data_q;
    if (load) begin
      vld_d[bus.sel]  = 1'b1;
      data_d[bus.sel] = bus.in_data;
    end
  end

  // Holding registers; data is cleared on reset so outputs are never unknown
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

`ifdef DEMUX_COUNT_EN
  logic [3:0][7:0] cnt_q, cnt_d;

  // Per-channel output transfer count, wrapping naturally at 8 bits
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i] + {7'd0, pop[i]};
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux1_4_stream.sv
// Self-checking bench for demux1_4_stream: a hand-derived vector table
// (inputs, expected in_ready and out_valid, optional data probe) plus a
// per-channel scoreboard that checks delivered words in acceptance order.
module tb_demux1_4_stream;

  logic clk = 1'b0;
  logic reset;

  demux1_4_stream_if #(.WIDTH(8)) bus ();

`ifdef DEMUX_COUNT_EN
  logic [31:0] cnt;
  demux1_4_stream #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus), .cnt(cnt));
`else
  demux1_4_stream #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [1:0] sel;
    logic [7:0] din;
    logic [3:0] ordy;
    logic       exp_rdy;
    logic [3:0] exp_ov;
    logic       chk_en;
    logic [1:0] chk_ch;
    logic [7:0] chk_dat;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  logic [7:0] sbq [4][$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Drive one cycle's inputs on the falling edge, settle, then return
  task automatic drive(input logic r, input logic iv, input logic [1:0] s,
                       input logic [7:0] d, input logic [3:0] o);
    @(negedge clk);
    reset         = r;
    bus.in_valid  = iv;
    bus.sel       = s;
    bus.in_data   = d;
    bus.out_ready = o;
    #1;
  endtask

  initial begin
    logic [7:0] got;
    logic [7:0] want;
    int ch;

    //          rst  iv   sel   din    ordy     rdy  ov       chk  ch    dat
    vecs[0]  = '{1'b0,1'b1,2'd2,8'hA5,4'b0000,1'b1,4'b0000,1'b0,2'd0,8'h00};
    vecs[1]  = '{1'b0,1'b0,2'd0,8'h00,4'b0000,1'b1,4'b0100,1'b1,2'd2,8'hA5};
    vecs[2]  = '{1'b0,1'b1,2'd1,8'h11,4'b0000,1'b1,4'b0100,1'b0,2'd0,8'h00};
    vecs[3]  = '{1'b0,1'b1,2'd1,8'h12,4'b0000,1'b0,4'b0110,1'b1,2'd1,8'h11};
    vecs[4]  = '{1'b0,1'b1,2'd1,8'h12,4'b0010,1'b1,4'b0110,1'b1,2'd1,8'h11};
    vecs[5]  = '{1'b0,1'b0,2'd0,8'h00,4'b0000,1'b1,4'b0110,1'b1,2'd1,8'h12};
    vecs[6]  = '{1'b0,1'b1,2'd0,8'h0C,4'b0000,1'b1,4'b0110,1'b0,2'd0,8'h00};
    vecs[7]  = '{1'b0,1'b1,2'd0,8'h0D,4'b0000,1'b0,4'b0111,1'b1,2'd0,8'h0C};
    vecs[8]  = '{1'b0,1'b1,2'd3,8'h3C,4'b0000,1'b1,4'b0111,1'b0,2'd0,8'h00};
    vecs[9]  = '{1'b0,1'b0,2'd3,8'h00,4'b0000,1'b0,4'b1111,1'b1,2'd0,8'h0C};
    vecs[10] = '{1'b0,1'b0,2'd0,8'h00,4'b0000,1'b0,4'b1111,1'b1,2'd3,8'h3C};
    vecs[11] = '{1'b0,1'b0,2'd0,8'h00,4'b1111,1'b1,4'b1111,1'b0,2'd0,8'h00};
    vecs[12] = '{1'b0,1'b1,2'd0,8'h11,4'b0001,1'b1,4'b0000,1'b0,2'd0,8'h00};
    vecs[13] = '{1'b0,1'b1,2'd0,8'h22,4'b0001,1'b1,4'b0001,1'b0,2'd0,8'h00};
    vecs[14] = '{1'b0,1'b1,2'd0,8'h33,4'b0001,1'b1,4'b0001,1'b0,2'd0,8'h00};
    vecs[15] = '{1'b0,1'b0,2'd0,8'h00,4'b0001,1'b1,4'b0001,1'b0,2'd0,8'h00};
    vecs[16] = '{1'b0,1'b1,2'd0,8'h40,4'b0000,1'b1,4'b0000,1'b0,2'd0,8'h00};
    vecs[17] = '{1'b0,1'b1,2'd1,8'h41,4'b0000,1'b1,4'b0001,1'b0,2'd0,8'h00};
    vecs[18] = '{1'b0,1'b1,2'd2,8'h42,4'b0000,1'b1,4'b0011,1'b0,2'd0,8'h00};
    vecs[19] = '{1'b0,1'b1,2'd3,8'h43,4'b0000,1'b1,4'b0111,1'b0,2'd0,8'h00};
    vecs[20] = '{1'b1,1'b1,2'd2,8'h99,4'b0000,1'b0,4'b1111,1'b1,2'd2,8'h42};
    vecs[21] = '{1'b0,1'b0,2'd0,8'h00,4'b0000,1'b1,4'b0000,1'b1,2'd2,8'h00};
    vecs[22] = '{1'b0,1'b1,2'd1,8'h77,4'b0000,1'b1,4'b0000,1'b0,2'd0,8'h00};
    vecs[23] = '{1'b0,1'b0,2'd0,8'h00,4'b0010,1'b1,4'b0010,1'b1,2'd1,8'h77};
    vecs[24] = '{1'b0,1'b0,2'd0,8'h00,4'b0000,1'b1,4'b0000,1'b1,2'd1,8'h77};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.sel       = 2'd0;
    bus.in_data   = 8'h00;
    bus.out_ready = 4'b0000;
    repeat (2) @(posedge clk);

    // Reset state, observed while reset is still high
    drive(1'b1, 1'b1, 2'd1, 8'h5A, 4'b0000);
    check("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("reset out_valid", {28'd0, bus.out_valid}, 32'd0);
    check("reset out_data", bus.out_data, 32'd0);
`ifdef DEMUX_COUNT_EN
    check("reset cnt", cnt, 32'd0);
`endif

    for (int v = 0; v < NV; v++) begin
      drive(vecs[v].rst, vecs[v].iv, vecs[v].sel, vecs[v].din, vecs[v].ordy);
      check($sformatf("v%0d in_ready", v), {31'd0, bus.in_ready}, {31'd0, vecs[v].exp_rdy});
      check($sformatf("v%0d out_valid", v), {28'd0, bus.out_valid}, {28'd0, vecs[v].exp_ov});
      if (vecs[v].chk_en) begin
        ch = int'(vecs[v].chk_ch);
        got = bus.out_data[ch*8 +: 8];
        check($sformatf("v%0d ch%0d data", v, ch), {24'd0, got}, {24'd0, vecs[v].chk_dat});
      end
      if (vecs[v].rst) begin
        for (int i = 0; i < 4; i++) sbq[i].delete();
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (bus.out_valid[i] && bus.out_ready[i]) begin
            got = bus.out_data[i*8 +: 8];
            if (sbq[i].size() == 0) begin
              n_total++;
              $display("FAIL v%0d ch%0d unexpected word actual=%h required=none", v, i, got);
            end else begin
              want = sbq[i].pop_front();
              check($sformatf("v%0d ch%0d order", v, i), {24'd0, got}, {24'd0, want});
            end
          end
        end
        if (bus.in_valid && bus.in_ready) sbq[bus.sel].push_back(bus.in_data);
      end
    end

    check("scoreboard leftover", sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size(), 32'd0);

`ifdef DEMUX_COUNT_EN
    // Counter wrap: one pop on channel 1, then 256 pops on channel 3
    drive(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000);
    drive(1'b0, 1'b1, 2'd1, 8'hC1, 4'b0000);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b0010);
    for (int k = 0; k < 256; k++) begin
      drive(1'b0, 1'b1, 2'd3, k[7:0], 4'b1000);
    end
    drive(1'b0, 1'b0, 2'd3, 8'h00, 4'b1000);
    check("cnt before wrap", cnt, 32'hFF00_0100);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
    check("cnt after wrap", cnt, 32'h0000_0100);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/demux1_4_stream.md
DEMUX1_4_STREAM -- requirements
Module: demux1_4_stream

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each channel in bits.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 Port: reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 Port: in_valid  input  1  upstream word present.
REQ-005 Port: in_ready  output  1  block accepts the upstream word this cycle.
REQ-006 Port: in_data  input  WIDTH  upstream word.
REQ-007 Port: sel  input  2  destination channel index, 0..3.
REQ-008 Port: out_valid  output  4  bit i: channel i holds a word.
REQ-009 Port: out_ready  input  4  bit i: channel i consumer takes the word.
REQ-010 Port: out_data  output  4*WIDTH  channel i at bits [i*WIDTH +: WIDTH].

Function
REQ-011 Each channel SHALL have exactly one holding register (data plus valid flag).
REQ-012 in_ready SHALL be combinational: (~out_valid[sel] | out_ready[sel]) & ~reset.
REQ-013 Input transfer SHALL occur when in_valid & in_ready; in_data is loaded into channel sel at that clock edge.
REQ-014 Load latency SHALL be 1 cycle: out_valid[sel]=1 and out_data[sel]=in_data from the cycle after the transfer.
REQ-015 Output transfer on channel i SHALL occur when out_valid[i] & out_ready[i]; out_valid[i] clears at that edge unless a load to i occurs.
REQ-016 Simultaneous pop and load on the same channel SHALL leave out_valid[i]=1 with the new word; no word is lost or duplicated.
REQ-017 While out_valid[i]=1 and out_ready[i]=0, out_data[i] SHALL be held stable.
REQ-018 Channels other than sel SHALL never be loaded; they drain independently and concurrently.
REQ-019 Full channel (out_valid[sel]=1, out_ready[sel]=0) SHALL deassert in_ready; upstream stalls with no data loss.
REQ-020 sel SHALL matter only in the transfer cycle; changing sel while stalled SHALL retarget the request to the new channel's state.
REQ-021 Word order per channel SHALL equal acceptance order.
REQ-022 out_data[i] SHALL be don't-care-free: it retains the last loaded word after a pop.

Reset
REQ-023 Reset SHALL clear all out_valid to 0 and all out_data to 0.
REQ-024 in_ready SHALL be 0 in every cycle reset is high; a word presented in that cycle is not accepted.
REQ-025 Reset mid-operation SHALL discard all held words; the first load after reset completes normally.

Configuration
REQ-026 Macro DEMUX_COUNT_EN SHALL compile in an output port cnt  output  32  four 8-bit counters, channel i at bits [i*8 +: 8].
REQ-027 With DEMUX_COUNT_EN, counter i SHALL increment on each channel-i output transfer, wrap 255->0, and reset to 0.
REQ-028 Without DEMUX_COUNT_EN, the cnt port and counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Reset, then in_valid=1, sel=2, in_data=0xA5, out_ready=0000 -> next cycle out_valid=0100 and channel 2 data=0xA5.
REQ-030 Channel 1 full, out_ready[1]=0, sel=1, in_valid=1 -> in_ready=0; raise out_ready[1] -> in_ready=1 and the new word replaces the old with out_valid[1] staying 1.
REQ-031 Channel 0 full and stalled, sel switched to 3 -> in_ready=1; word lands in channel 3 and channel 0 data is unchanged.
REQ-032 Words 0x11, 0x22 and 0x33 sent to channel 0 with out_ready[0]=1 -> consumer sees 0x11, 0x22, 0x33 in order, one per cycle.
REQ-033 Reset asserted while all four channels are valid -> next cycle out_valid=0000, out_data=0, and in_ready=0 during reset.
REQ-034 DEMUX_COUNT_EN: 256 pops on channel 3 -> channel 3 count reads 0 after wrap; other counters unchanged.
